// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
//   Transaction-level I2C master write sequencer. It accepts a write command
//   (7-bit address plus data byte count) and generates the START condition.
//   It then hands the address byte and each data byte to the byte controller
//   through a start/done/error handshake, and finishes with a STOP condition.
//   The sequencer owns the SDA/SCL lines only during START, STOP and while
//   waiting for the next data byte. Between bytes SCL is held low, so the
//   master stretches the clock.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_tick                   quarter-bit strobe shared with the byte controller
//   i_cmd_*/o_cmd_ready      command handshake (addr, len; len=0 is a probe)
//   i_data*/o_data_ready     data byte handshake
//   o_tx_start/o_tx_data     byte controller request (one-cycle start pulse)
//   i_tx_done/i_tx_error     byte controller result pulses
//   i_scl                    sampled SCL line, used to detect stretching
//   o_bus_owner              1 = sequencer lines drive the bus
//   o_sda/o_scl, *_disable   sequencer line values; disable=1 releases the line
//   o_busy/o_done/o_nack     status; o_nack_index = failing byte (0 = address)
module i2c_write_sequencer #(
  parameter int LEN_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [7:0]       i_data,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_done,
  input  logic             i_tx_error,
  input  logic             i_scl,
  output logic             o_bus_owner,
  output logic             o_sda,
  output logic             o_scl,
  output logic             o_sda_disable,
  output logic             o_scl_disable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack,
  output logic [LEN_W:0]   o_nack_index
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WAIT_DATA,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             sent_q, sent_d;
  logic             abort_q, abort_d;
  logic [LEN_W:0]   nack_index_q, nack_index_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic [LEN_W:0]   idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 2'd0;
      addr_q       <= 7'd0;
      len_q        <= '0;
      idx_q        <= '0;
      tx_data_q    <= 8'd0;
      sent_q       <= 1'b0;
      abort_q      <= 1'b0;
      nack_index_q <= '0;
      done_q       <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      sent_q       <= sent_d;
      abort_q      <= abort_d;
      nack_index_q <= nack_index_d;
      done_q       <= done_d;
      nack_q       <= nack_d;
    end
  end

  // Next-state logic. START and STOP walk four tick-paced phases. Phases 0
  // of START and 1 of STOP also wait for SCL to read high, because a slave
  // may stretch the clock there.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    sent_d       = sent_q;
    abort_d      = abort_q;
    nack_index_d = nack_index_q;
    done_d       = 1'b0;
    nack_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A tick coincident with accept is deliberately not consumed.
        if (i_cmd_valid) begin
          addr_d       = i_cmd_addr;
          len_d        = i_cmd_len;
          idx_d        = '0;
          abort_d      = 1'b0;
          nack_index_d = '0;
          phase_d      = 2'd0;
          state_d      = ST_START;
        end
      end

      ST_START: begin
        if (i_tick) begin
          case (phase_q)
            2'd0: if (i_scl) phase_d = 2'd1;
            2'd1: phase_d = 2'd2;
            2'd2: phase_d = 2'd3;
            default: begin
              tx_data_d = {addr_q, 1'b0};
              sent_d    = 1'b0;
              state_d   = ST_ADDR;
            end
          endcase
        end
      end

      ST_ADDR, ST_DATA: begin
        // sent_q suppresses a second start pulse while waiting for the result.
        sent_d = 1'b1;
        if (i_tx_error) begin
          nack_index_d = idx_q;
          abort_d      = 1'b1;
          phase_d      = 2'd0;
          state_d      = ST_STOP;
        end else if (i_tx_done) begin
          if (state_q == ST_ADDR) begin
            idx_d = {{LEN_W{1'b0}}, 1'b1};
            if (len_q == '0) begin
              phase_d = 2'd0;
              state_d = ST_STOP;
            end else begin
              state_d = ST_WAIT_DATA;
            end
          end else begin
            idx_d = idx_inc;
            if (idx_inc > {1'b0, len_q}) begin
              phase_d = 2'd0;
              state_d = ST_STOP;
            end else begin
              state_d = ST_WAIT_DATA;
            end
          end
        end
      end

      ST_WAIT_DATA: begin
        if (i_data_valid) begin
          tx_data_d = i_data;
          sent_d    = 1'b0;
          state_d   = ST_DATA;
        end
      end

      ST_STOP: begin
        if (i_tick) begin
          case (phase_q)
            2'd0: phase_d = 2'd1;
            2'd1: if (i_scl) phase_d = 2'd2;
            2'd2: phase_d = 2'd3;
            default: begin
              if (abort_q) nack_d = 1'b1;
              else         done_d = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Line and handshake decode from the registered state. Reset therefore
  // releases both lines at once. While the byte controller owns the bus, the
  // sequencer's own SCL stays driven low, so a handover never produces a
  // spurious clock edge.
  always_comb begin
    o_bus_owner   = 1'b1;
    o_sda         = 1'b1;
    o_scl         = 1'b1;
    o_sda_disable = 1'b1;
    o_scl_disable = 1'b1;
    o_cmd_ready   = 1'b0;
    o_data_ready  = 1'b0;
    o_tx_start    = 1'b0;

    case (state_q)
      ST_IDLE: o_cmd_ready = 1'b1;

      ST_START: begin
        if (phase_q != 2'd0) begin
          o_sda         = 1'b0;
          o_sda_disable = 1'b0;
        end
        if (phase_q[1]) begin
          o_scl         = 1'b0;
          o_scl_disable = 1'b0;
        end
      end

      ST_ADDR, ST_DATA: begin
        o_bus_owner   = 1'b0;
        o_tx_start    = !sent_q;
        o_scl         = 1'b0;
        o_scl_disable = 1'b0;
      end

      ST_WAIT_DATA: begin
        o_data_ready  = 1'b1;
        o_scl         = 1'b0;
        o_scl_disable = 1'b0;
      end

      ST_STOP: begin
        if (!phase_q[1]) begin
          o_sda         = 1'b0;
          o_sda_disable = 1'b0;
        end
        if (phase_q == 2'd0) begin
          o_scl         = 1'b0;
          o_scl_disable = 1'b0;
        end
      end

      default: ;
    endcase
  end

  assign o_tx_data    = tx_data_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_nack       = nack_q;
  assign o_nack_index = nack_index_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed testbench for i2c_write_sequencer. The bench plays the role of
// the byte controller and of the I2C bus, including SCL stretching on the
// sequencer-owned lines.
module tb_i2c_write_sequencer;

  localparam int LEN_W = 5;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_tick;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [6:0]       i_cmd_addr;
  logic [LEN_W-1:0] i_cmd_len;
  logic             i_data_valid;
  logic             o_data_ready;
  logic [7:0]       i_data;
  logic             o_tx_start;
  logic [7:0]       o_tx_data;
  logic             i_tx_done;
  logic             i_tx_error;
  logic             i_scl;
  logic             o_bus_owner;
  logic             o_sda;
  logic             o_scl;
  logic             o_sda_disable;
  logic             o_scl_disable;
  logic             o_busy;
  logic             o_done;
  logic             o_nack;
  logic [LEN_W:0]   o_nack_index;

  logic stretch;
  logic scl_line;

  int total;
  int bad;
  int n;

  int start_pulses, done_cnt, nack_cnt, ready_cnt, gap_bad;
  int start_cnt, stop_cnt, sda_early;
  logic [7:0] tx_q[$];
  logic prev_sda, prev_scl, sda_l, scl_l;

  i2c_write_sequencer #(.LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .i_tx_error(i_tx_error),
    .i_scl(i_scl), .o_bus_owner(o_bus_owner),
    .o_sda(o_sda), .o_scl(o_scl),
    .o_sda_disable(o_sda_disable), .o_scl_disable(o_scl_disable),
    .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack),
    .o_nack_index(o_nack_index)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Quarter-bit strobe: one cycle high every four clocks.
  initial begin
    i_tick = 1'b0;
    forever begin
      repeat (3) @(negedge i_clk);
      i_tick = 1'b1;
      @(negedge i_clk);
      i_tick = 1'b0;
    end
  end

  // Bus model: SCL reads high when released unless a slave stretches it.
  assign scl_line = o_bus_owner ? (o_scl_disable ? 1'b1 : o_scl) : 1'b1;
  assign i_scl    = scl_line & ~stretch;

  // Bus monitor. It samples shortly after each rising edge.
  initial begin
    prev_sda = 1'b1;
    prev_scl = 1'b1;
  end

  always @(posedge i_clk) begin
    #2;
    if (o_tx_start) begin
      start_pulses++;
      tx_q.push_back(o_tx_data);
    end
    if (o_done) done_cnt++;
    if (o_nack) nack_cnt++;
    if (o_data_ready) begin
      ready_cnt++;
      if (!(o_bus_owner && !o_scl_disable && !o_scl)) gap_bad++;
    end
    if (o_bus_owner) begin
      sda_l = o_sda_disable ? 1'b1 : o_sda;
      scl_l = o_scl_disable ? 1'b1 : o_scl;
      if (prev_sda && !sda_l && scl_l && prev_scl) start_cnt++;
      if (!prev_sda && sda_l && scl_l && prev_scl) begin
        stop_cnt++;
        if (stretch) sda_early++;
      end
      prev_sda = sda_l;
      prev_scl = scl_l;
    end
  end

  task automatic clear_counts();
    start_pulses = 0; done_cnt = 0; nack_cnt = 0; ready_cnt = 0;
    gap_bad = 0; start_cnt = 0; stop_cnt = 0; sda_early = 0;
    tx_q.delete();
  endtask

  task automatic send_cmd(input logic [6:0] addr, input logic [LEN_W-1:0] len);
    @(negedge i_clk);
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    n = 0;
    while (!o_cmd_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("[TB] FAIL cmd_accept: o_cmd_ready=%0b required 1", o_cmd_ready);
    end
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic push_data(input logic [7:0] b);
    @(negedge i_clk);
    i_data       = b;
    i_data_valid = 1'b1;
    n = 0;
    while (!o_data_ready && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("[TB] FAIL data_accept: o_data_ready=%0b required 1", o_data_ready);
    end
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic respond(input logic d, input logic e);
    n = 0;
    while (!o_tx_start && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("[TB] FAIL tx_start_wait: o_tx_start=%0b required 1", o_tx_start);
    end
    repeat (6) @(negedge i_clk);
    i_tx_done  = d;
    i_tx_error = e;
    @(negedge i_clk);
    i_tx_done  = 1'b0;
    i_tx_error = 1'b0;
  endtask

  task automatic wait_end();
    n = 0;
    while ((done_cnt + nack_cnt) == 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("[TB] FAIL end_wait: done+nack=%0d required >0", done_cnt + nack_cnt);
    end
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({o_cmd_ready, o_data_ready, o_tx_start, o_bus_owner, o_sda, o_scl,
         o_sda_disable, o_scl_disable, o_busy, o_done, o_nack} !== 11'b10011111000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b required %b",
               {o_cmd_ready, o_data_ready, o_tx_start, o_bus_owner, o_sda, o_scl,
                o_sda_disable, o_scl_disable, o_busy, o_done, o_nack}, 11'b10011111000);
    end
    total++;
    if (o_tx_data !== 8'h00 || o_nack_index !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: tx_data=%0h nack_index=%0d required 0 0",
               o_tx_data, o_nack_index);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    total++;
    if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: busy=%0b ready=%0b required 0 1",
               o_busy, o_cmd_ready);
    end
  endtask

  task automatic test_probe();
    clear_counts();
    send_cmd(7'h50, 5'd0);
    respond(1'b1, 1'b0);
    wait_end();
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL probe_done_cycle: done=%0b busy=%0b ready=%0b required 1 0 1",
               o_done, o_busy, o_cmd_ready);
    end
    repeat (10) @(negedge i_clk);
    total++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'hA0) begin
      bad++;
      $display("[TB] FAIL probe_tx: count=%0d first=%0h required 1 a0",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    total++;
    if (start_cnt != 1 || stop_cnt != 1) begin
      bad++;
      $display("[TB] FAIL probe_conditions: start=%0d stop=%0d required 1 1",
               start_cnt, stop_cnt);
    end
    total++;
    if (done_cnt != 1 || nack_cnt != 0 || ready_cnt != 0) begin
      bad++;
      $display("[TB] FAIL probe_pulses: done=%0d nack=%0d ready=%0d required 1 0 0",
               done_cnt, nack_cnt, ready_cnt);
    end
  endtask

  task automatic test_three_byte();
    logic [7:0] exp [4];
    exp[0] = 8'h78; exp[1] = 8'h00; exp[2] = 8'hAF; exp[3] = 8'h55;
    clear_counts();
    send_cmd(7'h3C, 5'd3);
    respond(1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      repeat (15) @(negedge i_clk);
      push_data(exp[i]);
      respond(1'b1, 1'b0);
    end
    wait_end();
    repeat (10) @(negedge i_clk);
    total++;
    if (tx_q.size() != 4) begin
      bad++;
      $display("[TB] FAIL three_count: got %0d required 4", tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (tx_q[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL three_byte%0d: got %0h required %0h", i, tx_q[i], exp[i]);
        end
      end
    end
    total++;
    if (gap_bad != 0 || ready_cnt == 0) begin
      bad++;
      $display("[TB] FAIL three_gap_scl: bad_cycles=%0d ready_cycles=%0d required 0 >0",
               gap_bad, ready_cnt);
    end
    total++;
    if (done_cnt != 1 || nack_cnt != 0 || start_cnt != 1 || stop_cnt != 1) begin
      bad++;
      $display("[TB] FAIL three_end: done=%0d nack=%0d start=%0d stop=%0d required 1 0 1 1",
               done_cnt, nack_cnt, start_cnt, stop_cnt);
    end
  endtask

  task automatic test_data_nack();
    clear_counts();
    send_cmd(7'h21, 5'd4);
    respond(1'b1, 1'b0);
    push_data(8'h11);
    respond(1'b1, 1'b0);
    push_data(8'h22);
    respond(1'b1, 1'b0);
    push_data(8'h33);
    respond(1'b0, 1'b1);
    wait_end();
    repeat (40) @(negedge i_clk);
    total++;
    if (nack_cnt != 1 || done_cnt != 0 || stop_cnt != 1) begin
      bad++;
      $display("[TB] FAIL dnack_pulses: nack=%0d done=%0d stop=%0d required 1 0 1",
               nack_cnt, done_cnt, stop_cnt);
    end
    total++;
    if (o_nack_index !== 6'd3) begin
      bad++;
      $display("[TB] FAIL dnack_index: got %0d required 3", o_nack_index);
    end
    total++;
    if (start_pulses != 4 || o_data_ready !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dnack_after: starts=%0d ready=%0b busy=%0b required 4 0 0",
               start_pulses, o_data_ready, o_busy);
    end
  endtask

  task automatic test_done_error_same();
    clear_counts();
    send_cmd(7'h44, 5'd1);
    respond(1'b1, 1'b1);
    wait_end();
    repeat (10) @(negedge i_clk);
    total++;
    if (nack_cnt != 1 || done_cnt != 0) begin
      bad++;
      $display("[TB] FAIL both_result: nack=%0d done=%0d required 1 0", nack_cnt, done_cnt);
    end
    total++;
    if (o_nack_index !== 6'd0 || start_pulses != 1) begin
      bad++;
      $display("[TB] FAIL both_index: index=%0d starts=%0d required 0 1",
               o_nack_index, start_pulses);
    end
  endtask

  task automatic test_addr_nack_stretch();
    int ticks;
    clear_counts();
    send_cmd(7'h12, 5'd2);
    respond(1'b0, 1'b1);
    stretch = 1'b1;
    ticks = 0;
    while (ticks < 10) begin
      @(posedge i_clk);
      #2;
      if (i_tick) ticks++;
    end
    total++;
    if (o_sda_disable !== 1'b0 || o_scl_disable !== 1'b1 || nack_cnt != 0) begin
      bad++;
      $display("[TB] FAIL stretch_hold: sda_dis=%0b scl_dis=%0b nack=%0d required 0 1 0",
               o_sda_disable, o_scl_disable, nack_cnt);
    end
    stretch = 1'b0;
    wait_end();
    repeat (10) @(negedge i_clk);
    total++;
    if (nack_cnt != 1 || o_nack_index !== 6'd0) begin
      bad++;
      $display("[TB] FAIL anack_result: nack=%0d index=%0d required 1 0",
               nack_cnt, o_nack_index);
    end
    total++;
    if (sda_early != 0 || stop_cnt != 1) begin
      bad++;
      $display("[TB] FAIL anack_stop: early=%0d stop=%0d required 0 1", sda_early, stop_cnt);
    end
    total++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h24) begin
      bad++;
      $display("[TB] FAIL anack_tx: count=%0d first=%0h required 1 24",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_data();
    clear_counts();
    send_cmd(7'h30, 5'd2);
    respond(1'b1, 1'b0);
    push_data(8'h5A);
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_sda_disable, o_scl_disable, o_busy, o_cmd_ready, o_bus_owner} !== 5'b11011) begin
      bad++;
      $display("[TB] FAIL midreset_lines: got %b required %b",
               {o_sda_disable, o_scl_disable, o_busy, o_cmd_ready, o_bus_owner}, 5'b11011);
    end
    repeat (5) @(negedge i_clk);
    total++;
    if (done_cnt != 0 || nack_cnt != 0 || stop_cnt != 0) begin
      bad++;
      $display("[TB] FAIL midreset_pulses: done=%0d nack=%0d stop=%0d required 0 0 0",
               done_cnt, nack_cnt, stop_cnt);
    end
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    clear_counts();
    send_cmd(7'h50, 5'd0);
    respond(1'b1, 1'b0);
    wait_end();
    repeat (5) @(negedge i_clk);
    total++;
    if (done_cnt != 1 || tx_q.size() != 1) begin
      bad++;
      $display("[TB] FAIL midreset_recover: done=%0d tx=%0d required 1 1",
               done_cnt, tx_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    i_rst_n = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr = 7'd0;
    i_cmd_len = '0;
    i_data_valid = 1'b0;
    i_data = 8'd0;
    i_tx_done = 1'b0;
    i_tx_error = 1'b0;
    stretch = 1'b0;
    clear_counts();
    test_reset();
    test_probe();
    test_three_byte();
    test_data_nack();
    test_done_error_same();
    test_addr_nack_stretch();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_write_sequencer.md
# i2c_write_sequencer

Transaction-level I2C master write sequencer sitting directly upstream of `i2c_tx_byte_controller`. It accepts a write command (7-bit address plus byte count) and generates the START condition. It then feeds the address byte and each data byte to the byte controller through its start/done/error handshake, and generates the STOP condition. It owns the SDA/SCL lines only during START, STOP and inter-byte holds. It reports completion or the index of the byte that was NACKed.

## Interface
- `LEN_W`, 5, width of byte-count field; max data bytes = 2^LEN_W-1
---
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_tick`  in  1  quarter-bit strobe, the same strobe that drives the byte controller
- `i_cmd_valid`  in  1  command present
- `o_cmd_ready`  out  1  sequencer idle, command accepted on valid&ready
- `i_cmd_addr`  in  7  target address
- `i_cmd_len`  in  LEN_W  number of data bytes (0 = address-only probe)
- `i_data_valid`  in  1  data byte present
- `o_data_ready`  out  1  data byte accepted on valid&ready
- `i_data`  in  8  data byte
- `o_tx_start`  out  1  one-cycle start pulse to byte controller
- `o_tx_data`  out  8  byte for byte controller, stable from the start pulse until done/error
- `i_tx_done`, `i_tx_error`  in  1 each  byte controller result pulses
- `i_scl`  in  1  sampled SCL line (stretch detection)
- `o_bus_owner`  out  1  1 = sequencer lines drive the bus, 0 = byte controller lines drive the bus
- `o_sda`, `o_scl`  out  1 each  sequencer line values
- `o_sda_disable`, `o_scl_disable`  out  1 each  1 = release the line
- `o_busy`  out  1  transaction in progress
- `o_done`  out  1  one-cycle pulse: all bytes ACKed, STOP issued
- `o_nack`  out  1  one-cycle pulse: transaction aborted on NACK, STOP issued
- `o_nack_index`  out  LEN_W+1  byte index that failed (0 = address); held until the next command

## Operation
- States: IDLE, START, ADDR, WAIT_DATA, DATA, STOP.
- IDLE
  - `o_cmd_ready`=1, `o_bus_owner`=1, both lines released.
  - On accept: latch addr and len, clear the byte index, go to START.
- START (phases advance only on `i_tick`)
  - S0: release SCL, SDA=1; remain until `i_scl`=1.
  - S1: SDA=0 (drive).
  - S2: SCL=0 (drive).
  - S3: go to ADDR.
- ADDR
  - Pulse `o_tx_start` with `o_tx_data`={addr,1'b0}; set `o_bus_owner`=0.
  - Wait for a result.
  - On done: index=1; if len=0 go to STOP, else go to WAIT_DATA.
- WAIT_DATA
  - `o_bus_owner`=1, SCL driven 0, SDA=1 (bus held, clock stretched by master).
  - `o_data_ready`=1.
  - On accept: go to DATA.
- DATA
  - Pulse `o_tx_start` with the accepted byte; set `o_bus_owner`=0.
  - On done: increment the index.
  - If the index exceeds len, go to STOP; else go to WAIT_DATA.
- On `i_tx_error` in ADDR or DATA
  - Set `o_nack_index` to the current index.
  - Set the abort flag and go to STOP.
- STOP (tick-advanced; sequencer owns the bus)
  - P0: SCL=0, SDA=0.
  - P1: release SCL; remain until `i_scl`=1.
  - P2: release SDA (SDA=1).
  - P3: pulse `o_done`, or `o_nack` if the abort flag is set; go to IDLE.
- Driven 0 means disable=0 and value=0. Released means disable=1 and value=1.

## Timing
- Reset values (asynchronous, all registers):
  - state=IDLE, `o_cmd_ready`=1, `o_data_ready`=0, `o_tx_start`=0, `o_tx_data`=0.
  - `o_bus_owner`=1, `o_sda`=1, `o_scl`=1, `o_sda_disable`=1, `o_scl_disable`=1.
  - `o_busy`=0, `o_done`=0, `o_nack`=0, `o_nack_index`=0.
- Reset mid-transaction: all lines are released immediately. No STOP is generated.
- Command accept cycle:
  - A coincident `i_tick` is not consumed; S0 starts on the next tick.
  - `o_busy` rises on the cycle after accept and falls with the done/nack pulse.
- `o_tx_start`:
  - Asserted exactly one cycle, on the first cycle in ADDR or DATA.
  - Not reissued while waiting for a result.
- `i_tx_done` and `i_tx_error` in the same cycle: error wins.
- Result pulses outside ADDR or DATA are ignored.
- `o_data_ready` is asserted only in WAIT_DATA; at most one data byte is accepted per WAIT_DATA visit.
- Data underflow is unbounded: the bus is held with SCL low indefinitely.
- Index width LEN_W+1; no wrap for len ≤ 2^LEN_W-1.
- Minimum ticks:
  - START: 4 (excluding stretch).
  - STOP: 4 (excluding stretch).

## Test plan
- Reset mid-DATA: assert `i_rst_n`=0 -> within the same cycle both disables=1, `o_busy`=0, `o_cmd_ready`=1; no `o_done` or `o_nack`.
- Address probe: cmd addr=0x50, len=0, model ACKs -> one `o_tx_start` with data 0xA0; START (SDA falls while SCL high) then STOP (SDA rises while SCL high); `o_done` pulses once; `o_data_ready` never asserts.
- Three-byte write: addr=0x3C, len=3, data 0x00, 0xAF, 0x55 presented with gaps -> `o_tx_data` sequence 0x78, 0x00, 0xAF, 0x55; SCL held low during gaps; `o_done` pulses once.
- Data NACK: len=4, error returned on the third byte -> `o_nack` pulses once, `o_nack_index`=3, STOP issued, no further `o_tx_start`.
- Address NACK plus stretch: error on the address byte; in STOP P1 hold `i_scl` low for 10 ticks -> SDA is released only after `i_scl` rises; `o_nack_index`=0.
- Simultaneous done and error: pulse both in ADDR -> treated as NACK; `o_nack`=1, `o_done` stays 0.
